// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of a 16-entry async FIFO: write-pointer sync,
// Gray/binary pointers, empty/level, RAM read strobe, underflow, gray_err.
//
// Ports:
//   clk, reset_n       read clock, synchronous active-low reset
//   wr_gptr_async[4:0] Gray write pointer from the write domain
//   rd_req             consumer pop request
//   rd_gptr[4:0]       registered Gray read pointer to the write domain
//   ram_rd_en          RAM read strobe (same cycle as an accepted pop)
//   ram_rd_addr[3:0]   RAM read address
//   rd_valid           RAM data valid, one cycle after ram_rd_en
//   empty              no entry readable
//   level[4:0]         readable entries, 0..16
//   underflow          one-cycle pulse for a pop rejected while empty
//   gray_err           sticky: synced write pointer broke Gray/range rules
module async_fifo_rd_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] wr_gptr_async,
  input  logic       rd_req,
  output logic [4:0] rd_gptr,
  output logic       ram_rd_en,
  output logic [3:0] ram_rd_addr,
  output logic       rd_valid,
  output logic       empty,
  output logic [4:0] level,
  output logic       underflow,
  output logic       gray_err
);

  logic [SYNC_STAGES-1:0][4:0] sync_q;
  logic [4:0] wr_gptr_s;
  logic [4:0] wr_bptr_s;
  logic [4:0] wr_gptr_prev;
  logic [4:0] gptr_diff;
  logic [4:0] rd_bptr;
  logic [4:0] rd_bptr_next;
  logic       accept;
  logic       gray_bad;

  // Plain flop chain; nothing between stages.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], wr_gptr_async};
    end
  end

  assign wr_gptr_s = sync_q[SYNC_STAGES-1];

  assign wr_bptr_s = {
    wr_gptr_s[4],
    ^wr_gptr_s[4:3],
    ^wr_gptr_s[4:2],
    ^wr_gptr_s[4:1],
    ^wr_gptr_s[4:0]
  };

  assign empty       = (wr_gptr_s == rd_gptr);
  assign level       = wr_bptr_s - rd_bptr;
  assign accept      = rd_req & ~empty;
  assign ram_rd_en   = accept;
  assign ram_rd_addr = rd_bptr[3:0];

  assign rd_bptr_next = rd_bptr + {4'd0, accept};

  // More than one bit changed <=> diff has more than one bit set.
  assign gptr_diff = wr_gptr_s ^ wr_gptr_prev;
  assign gray_bad  = (|(gptr_diff & (gptr_diff - 5'd1)))
                   | (level > 5'd16);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_bptr      <= '0;
      rd_gptr      <= '0;
      rd_valid     <= 1'b0;
      underflow    <= 1'b0;
      wr_gptr_prev <= '0;
      gray_err     <= 1'b0;
    end else begin
      rd_bptr      <= rd_bptr_next;
      rd_gptr      <= rd_bptr_next ^ (rd_bptr_next >> 1);
      rd_valid     <= accept;
      underflow    <= rd_req & empty;
      wr_gptr_prev <= wr_gptr_s;
      if (gray_bad) begin
        gray_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Scoreboard bench for async_fifo_rd_ctrl: directed vectors,
// queued expectations checked by a negedge monitor.
module tb_async_fifo_rd_ctrl;

  logic       clk;
  logic       reset_n;
  logic [4:0] wr_gptr_async;
  logic       rd_req;
  logic [4:0] rd_gptr;
  logic       ram_rd_en;
  logic [3:0] ram_rd_addr;
  logic       rd_valid;
  logic       empty;
  logic [4:0] level;
  logic       underflow;
  logic       gray_err;

  async_fifo_rd_ctrl #(.SYNC_STAGES(2)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .wr_gptr_async(wr_gptr_async),
    .rd_req(rd_req),
    .rd_gptr(rd_gptr),
    .ram_rd_en(ram_rd_en),
    .ram_rd_addr(ram_rd_addr),
    .rd_valid(rd_valid),
    .empty(empty),
    .level(level),
    .underflow(underflow),
    .gray_err(gray_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int n_pops = 0;
  int n_valid = 0;

  logic [3:0] addr_q [$];
  bit         uf_q [$];

  logic [4:0] wbin = '0;
  logic [4:0] rbin = '0;
  logic       prev_en = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [4:0] gray(logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_step();
    wbin = wbin + 5'd1;
    wr_gptr_async = gray(wbin);
  endtask

  task automatic pop_issue();
    rd_req = 1'b1;
    addr_q.push_back(rbin[3:0]);
    n_pops++;
  endtask

  // Monitor: consumes expectations when the DUT shows an output.
  always @(negedge clk) begin
    if (prev_en || rd_valid) begin
      check("rd_valid_latency", {31'd0, rd_valid}, {31'd0, prev_en});
      if (rd_valid) n_valid++;
    end
    if (ram_rd_en) begin
      if (addr_q.size() == 0) begin
        check("unexpected_rd_en", 32'd1, 32'd0);
      end else begin
        check("ram_rd_addr", {28'd0, ram_rd_addr},
              {28'd0, addr_q.pop_front()});
      end
    end
    prev_en = ram_rd_en;
    if (underflow) begin
      if (uf_q.size() == 0) begin
        check("unexpected_underflow", 32'd1, 32'd0);
      end else begin
        void'(uf_q.pop_front());
        check("underflow_pulse", 32'd1, 32'd1 & {31'd0, underflow});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    wr_gptr_async = '0;
    rd_req = 1'b0;
    tick(); tick(); tick();
    reset_n = 1'b1;
    tick();
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_level", {27'd0, level}, 32'd0);
    check("rst_rd_gptr", {27'd0, rd_gptr}, 32'd0);
    check("rst_ram_rd_en", {31'd0, ram_rd_en}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_underflow", {31'd0, underflow}, 32'd0);
    check("rst_gray_err", {31'd0, gray_err}, 32'd0);

    // Three writes: 00001, 00011, 00010.
    wr_gptr_async = 5'b00001; tick();
    wr_gptr_async = 5'b00011; tick();
    wr_gptr_async = 5'b00010; wbin = 5'd3;
    tick();
    check("sync_lat_level", {27'd0, level}, 32'd2);
    tick();
    check("three_wr_level", {27'd0, level}, 32'd3);
    check("three_wr_empty", {31'd0, empty}, 32'd0);

    for (int i = 0; i < 3; i++) begin
      pop_issue();
      tick();
      rbin = rbin + 5'd1;
    end
    rd_req = 1'b0;
    check("pop3_rd_gptr", {27'd0, rd_gptr}, 32'b00010);
    check("pop3_empty", {31'd0, empty}, 32'd1);
    check("pop3_level", {27'd0, level}, 32'd0);
    tick();

    // Pops while empty.
    for (int i = 0; i < 3; i++) begin
      rd_req = 1'b1;
      uf_q.push_back(1'b1);
      #1;
      check("uf_ram_rd_en", {31'd0, ram_rd_en}, 32'd0);
      tick();
    end
    rd_req = 1'b0;
    check("uf_rd_gptr", {27'd0, rd_gptr}, 32'b00010);
    tick();
    check("uf_cleared", {31'd0, underflow}, 32'd0);

    // Prefill 8, then 40 simultaneous write+pop across the wrap.
    for (int i = 0; i < 8; i++) begin
      wr_step();
      tick();
    end
    tick(); tick();
    check("prefill_level", {27'd0, level}, 32'd8);
    for (int i = 0; i < 40; i++) begin
      wr_step();
      pop_issue();
      tick();
      rbin = rbin + 5'd1;
      check("wrap_rd_gptr", {27'd0, rd_gptr}, {27'd0, gray(rbin)});
      check("wrap_level_max", {31'd0, level > 5'd16}, 32'd0);
      check("wrap_gray_err", {31'd0, gray_err}, 32'd0);
    end
    rd_req = 1'b0;
    tick(); tick(); tick();
    check("post_wrap_level", {27'd0, level}, 32'd8);
    for (int i = 0; i < 8; i++) begin
      pop_issue();
      tick();
      rbin = rbin + 5'd1;
    end
    rd_req = 1'b0;
    check("drain_empty", {31'd0, empty}, 32'd1);
    check("drain_rd_gptr", {27'd0, rd_gptr}, 32'b11010);
    tick();

    // Reset with seven entries pending.
    for (int i = 0; i < 7; i++) begin
      wr_step();
      tick();
    end
    tick(); tick();
    check("pre_rst_level", {27'd0, level}, 32'd7);
    reset_n = 1'b0;
    tick();
    check("mid_rst_empty", {31'd0, empty}, 32'd1);
    check("mid_rst_level", {27'd0, level}, 32'd0);
    check("mid_rst_rd_gptr", {27'd0, rd_gptr}, 32'd0);
    check("mid_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("mid_rst_gray_err", {31'd0, gray_err}, 32'd0);
    wr_gptr_async = '0; wbin = '0; rbin = '0;
    tick();
    reset_n = 1'b1;
    tick();

    // Two-bit jump on the write pointer.
    wr_gptr_async = 5'b00011;
    tick(); tick();
    check("jump_err_early", {31'd0, gray_err}, 32'd0);
    tick();
    check("jump_err_set", {31'd0, gray_err}, 32'd1);
    tick(); tick(); tick();
    check("jump_err_sticky", {31'd0, gray_err}, 32'd1);
    reset_n = 1'b0;
    wr_gptr_async = '0;
    tick();
    check("jump_err_rst", {31'd0, gray_err}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Level past 16 flags an error; 16 does not.
    for (int i = 0; i < 16; i++) begin
      wr_step();
      tick();
    end
    tick(); tick(); tick();
    check("full_level", {27'd0, level}, 32'd16);
    check("full_no_err", {31'd0, gray_err}, 32'd0);
    wr_step();
    tick(); tick();
    check("over_level", {27'd0, level}, 32'd17);
    check("over_err_early", {31'd0, gray_err}, 32'd0);
    tick();
    check("over_err_set", {31'd0, gray_err}, 32'd1);

    tick(); tick();
    check("addr_q_drained", addr_q.size(), 32'd0);
    check("uf_q_drained", uf_q.size(), 32'd0);
    check("valid_count", n_valid, n_pops);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/async_fifo_rd_ctrl.md
ASYNC_FIFO_RD_CTRL -- requirements
Module: async_fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on the incoming write pointer (legal 2..4).
REQ-002 SHALL have port clk  input  1  read-domain clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port wr_gptr_async  input  5  write pointer in reflected Gray code from the write clock domain; asynchronous to clk.
REQ-005 SHALL have port rd_req  input  1  consumer request to pop one entry.
REQ-006 SHALL have port rd_gptr  output  5  registered read pointer in reflected Gray code, returned to the write domain.
REQ-007 SHALL have port ram_rd_en  output  1  read strobe to the 16-entry FIFO RAM.
REQ-008 SHALL have port ram_rd_addr  output  4  RAM read address.
REQ-009 SHALL have port rd_valid  output  1  RAM read data valid (one cycle after ram_rd_en).
REQ-010 SHALL have port empty  output  1  no entry available for reading.
REQ-011 SHALL have port level  output  5  entries currently readable, 0..16.
REQ-012 SHALL have port underflow  output  1  one-cycle pulse: rd_req rejected because empty.
REQ-013 SHALL have port gray_err  output  1  sticky flag: synchronized write pointer violated Gray/range rules.

Function
REQ-014 SHALL pass wr_gptr_async through SYNC_STAGES flops; last stage is wr_gptr_s; no logic between stages.
REQ-015 SHALL convert wr_gptr_s to binary wr_bptr_s by b[i] = XOR of g[4:i].
REQ-016 SHALL hold a 5-bit binary read pointer rd_bptr; rd_gptr SHALL be a register loaded with rd_bptr_next ^ (rd_bptr_next >> 1), so rd_gptr changes at most one bit per edge.
REQ-017 SHALL compute empty = (wr_gptr_s == rd_gptr), combinationally from registers.
REQ-018 SHALL compute level = (wr_bptr_s - rd_bptr) modulo 32, combinationally from registers.
REQ-019 SHALL define accept = rd_req & ~empty; ram_rd_en = accept; ram_rd_addr = rd_bptr[3:0] (combinational, same cycle).
REQ-020 On accept, rd_bptr and rd_gptr SHALL advance by one at the next edge; otherwise hold.
REQ-021 rd_valid SHALL be a register equal to accept from the previous cycle (latency 1).
REQ-022 rd_req & empty SHALL leave pointers unchanged and register underflow = 1 for exactly the next cycle.
REQ-023 Pointer wrap: rd_bptr 31 -> 0, rd_gptr 10000 -> 00000 with no special handling.
REQ-024 Write-pointer advance and accept in the same cycle SHALL both take effect; empty/level reflect the new values next cycle.
REQ-025 A write advance SHALL reach empty/level no earlier than SYNC_STAGES edges after wr_gptr_async changes.
REQ-026 gray_err SHALL set when wr_gptr_s differs from its previous-cycle value in more than one bit, or when level > 16; SHALL stay set until reset.
REQ-027 gray_err SHALL NOT alter pointer, empty or level behaviour.

Reset
REQ-028 While reset_n = 0 at an edge: all synchronizer stages, rd_bptr, rd_gptr, rd_valid, underflow, gray_err SHALL load 0.
REQ-029 Consequently after reset: empty = 1, level = 0, ram_rd_en = 0; reset mid-operation discards all pending state; the write domain is reset concurrently by the system.
REQ-030 The previous-value register used by REQ-026 SHALL reset to 0 so the first post-reset sample raises no error.

Verification
REQ-031 Reset then wr_gptr_async = 00000 -> empty = 1, level = 0, rd_gptr = 00000, all flags 0.
REQ-032 Step wr_gptr_async 00000 -> 00001 -> 00011 -> 00010 (3 writes), SYNC_STAGES = 2 -> level reaches 3 no earlier than 2 edges after last change; three rd_req pops give ram_rd_addr 0,1,2, rd_valid one cycle after each, rd_gptr ends 00010, empty = 1.
REQ-033 rd_req held with empty = 1 -> ram_rd_en = 0, underflow pulses 1 cycle per rejected request, rd_gptr unchanged.
REQ-034 Drive 40 writes/reads interleaved across wrap -> rd_gptr sequence 11000 ... 10000 -> 00000, level never > 16, gray_err = 0.
REQ-035 Jump wr_gptr_async 00000 -> 00011 in one step -> gray_err = 1 after sync latency and stays 1 until reset_n = 0.
REQ-036 Assert reset_n = 0 with level = 7 mid-stream -> next edge all outputs at reset values, empty = 1.
